// File: rtl/axilite_pkg.sv
// Shared definitions for the AXI4-Lite memory slave.
// Holds the response codes, the write/read channel state enums and a
// compile-time log2 helper used to size address slices.
package axilite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // W_ADDR: address captured, waiting for data.
  // W_DATA: data/strobes captured, waiting for address.
  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  // Smallest n with (1 << n) >= value; 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/axilite_mem_ram.sv
// Word memory behind the AXI4-Lite slave.
// DEPTH words of DATA_W bits, one synchronous write port with per-byte
// enables and one asynchronous read port. Contents are not reset.
// Ports:
//   clk    in   clock, write on rising edge
//   we     in   write enable for the whole word
//   wstrb  in   byte-lane enables, lane i written only if wstrb[i]
//   waddr  in   write word index
//   wdata  in   write data
//   raddr  in   read word index
//   rdata  out  read data (combinational from raddr)
module axilite_mem_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int IDX_W  = 7
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DATA_W / 8; i++) begin
        if (wstrb[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Read happens before any same-edge write lands, so a capture on the
  // commit edge sees the old word.
  assign rdata = mem[raddr];

endmodule

// File: rtl/axilite_mem_s.sv
// AXI4-Lite slave fronting a byte-enabled word memory.
// Independent write and read channels; AW and W may arrive in either order
// or together; out-of-range accesses answer SLVERR without touching memory
// and reads of them return zero.
// Ports:
//   s_axi_aclk / s_axi_aresetn   clock, asynchronous active-low reset
//   s_axi_aw*                    write address channel (valid/ready/addr)
//   s_axi_w*                     write data channel (valid/ready/data/strb)
//   s_axi_b*                     write response channel (valid/ready/resp)
//   s_axi_ar*                    read address channel (valid/ready/addr)
//   s_axi_r*                     read data channel (valid/ready/data/resp)
module axilite_mem_s
  import axilite_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 128
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [ADDR_W-1:0]     s_axi_awaddr,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  input  logic [DATA_W-1:0]     s_axi_wdata,
  input  logic [DATA_W/8-1:0]   s_axi_wstrb,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  output logic [1:0]            s_axi_bresp,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  input  logic [ADDR_W-1:0]     s_axi_araddr,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [DATA_W-1:0]     s_axi_rdata,
  output logic [1:0]            s_axi_rresp
);

  localparam int STRB_W    = DATA_W / 8;
  localparam int ADDR_LSB  = clog2(STRB_W);
  localparam int IDX_W     = clog2(DEPTH);
  localparam int RANGE_LSB = ADDR_LSB + IDX_W;

  // Memory spans exactly 2**RANGE_LSB bytes, so any set bit above that is
  // out of range.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return (addr >> RANGE_LSB) == '0;
  endfunction

  wr_state_t wr_state, wr_state_next;
  rd_state_t rd_state, rd_state_next;

  // Holds the readies low for the first edge after reset release.
  logic ready_en;

  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [1:0]        bresp_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;

  logic aw_hs, w_hs, ar_hs;
  logic commit, commit_ok, ar_ok;
  logic [ADDR_W-1:0] commit_addr;
  logic [DATA_W-1:0] commit_data;
  logic [STRB_W-1:0] commit_strb;
  logic [DATA_W-1:0] ram_rdata;

  // State register for both channels.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
      ready_en <= 1'b0;
    end else begin
      wr_state <= wr_state_next;
      rd_state <= rd_state_next;
      ready_en <= 1'b1;
    end
  end

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid  & s_axi_wready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;

  // Next-state logic.
  always_comb begin
    wr_state_next = wr_state;
    case (wr_state)
      W_IDLE: begin
        if (aw_hs && w_hs) wr_state_next = W_RESP;
        else if (aw_hs)    wr_state_next = W_ADDR;
        else if (w_hs)     wr_state_next = W_DATA;
      end
      W_ADDR:  if (w_hs)  wr_state_next = W_RESP;
      W_DATA:  if (aw_hs) wr_state_next = W_RESP;
      W_RESP:  if (s_axi_bready) wr_state_next = W_IDLE;
      default: wr_state_next = W_IDLE;
    endcase

    rd_state_next = rd_state;
    case (rd_state)
      R_IDLE:  if (ar_hs) rd_state_next = R_DATA;
      R_DATA:  if (s_axi_rready) rd_state_next = R_IDLE;
      default: rd_state_next = R_IDLE;
    endcase
  end

  // Moore output decode of the registered state.
  always_comb begin
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    case (wr_state)
      W_IDLE: begin
        s_axi_awready = ready_en;
        s_axi_wready  = ready_en;
      end
      W_ADDR:  s_axi_wready  = 1'b1;
      W_DATA:  s_axi_awready = 1'b1;
      W_RESP:  s_axi_bvalid  = 1'b1;
      default: ;
    endcase
    case (rd_state)
      R_IDLE:  s_axi_arready = ready_en;
      R_DATA:  s_axi_rvalid  = 1'b1;
      default: ;
    endcase
  end

  // The half that arrives second comes straight from the bus; the half that
  // arrived first comes from its holding register.
  always_comb begin
    commit_addr = (wr_state == W_ADDR) ? aw_addr_q : s_axi_awaddr;
    commit_data = (wr_state == W_DATA) ? wdata_q   : s_axi_wdata;
    commit_strb = (wr_state == W_DATA) ? wstrb_q   : s_axi_wstrb;
  end

  assign commit    = (wr_state_next == W_RESP) && (wr_state != W_RESP);
  assign commit_ok = addr_in_range(commit_addr);
  assign ar_ok     = addr_in_range(s_axi_araddr);

  // Holding and response registers.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      aw_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      if (aw_hs) aw_addr_q <= s_axi_awaddr;
      if (w_hs) begin
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
      if (commit) bresp_q <= commit_ok ? RESP_OKAY : RESP_SLVERR;
      if (ar_hs) begin
        rdata_q <= ar_ok ? ram_rdata : '0;
        rresp_q <= ar_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign s_axi_bresp = bresp_q;
  assign s_axi_rdata = rdata_q;
  assign s_axi_rresp = rresp_q;

  axilite_mem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk   (s_axi_aclk),
    .we    (commit & commit_ok),
    .wstrb (commit_strb),
    .waddr (commit_addr[ADDR_LSB +: IDX_W]),
    .wdata (commit_data),
    .raddr (s_axi_araddr[ADDR_LSB +: IDX_W]),
    .rdata (ram_rdata)
  );

endmodule
